// File: rtl/testboard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : testboard_pkg                                               |
// | Description: Shared types and golden model for the Liberty74 testboard   |
// |              self-test sequencer.                                        |
// |              - state_e       : sequencer state encoding                  |
// |              - NUM_RESULTS   : number of gate result bits (16)           |
// |              - NUM_PATTERNS  : number of switch patterns walked (8)      |
// |              - golden_result : expected gate outputs for a pattern       |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package testboard_pkg;

    localparam int NUM_RESULTS  = 16;
    localparam int NUM_PATTERNS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Expected gate array outputs for switch pattern p (a=p[0], b=p[1], c=p[2]).
    function automatic logic [NUM_RESULTS-1:0] golden_result(input logic [2:0] p);
        logic a;
        logic b;
        logic c;
        logic [NUM_RESULTS-1:0] r;
        a = p[0];
        b = p[1];
        c = p[2];
        r[0]  = a;
        r[1]  = a;
        r[2]  = ~a;
        r[3]  = c ? b : a;
        r[4]  = a & b;
        r[5]  = a & b & c;
        r[6]  = ~(a & b);
        r[7]  = ~(a & b & c);
        r[8]  = a | b;
        r[9]  = a | b | c;
        r[10] = ~(a | b);
        r[11] = ~(a | b | c);
        r[12] = (a & b) | c;
        r[13] = (a | b) & c;
        r[14] = a ^ b;
        r[15] = a ^ b ^ c;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/testboard_selftest_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : testboard_selftest_seq                                      |
// | Description: Self-test sequencer for the Liberty74 testboard gate array. |
// |              Walks all 8 switch patterns, waits SETTLE_CYCLES per        |
// |              pattern, samples the 16 gate results once and accumulates   |
// |              mismatches against the golden model.                        |
// | Parameters : SETTLE_CYCLES (>=1) settle delay per pattern                |
// |              ERR_CNT_W          width of the saturating error counter    |
// | Macro      : SELFTEST_LOOP_EN - when defined, the sequencer keeps        |
// |              looping over the patterns while start_i is high, pulsing    |
// |              done_o once per pass.                                       |
// | Ports      : clk_i          in   board clock                             |
// |              rst_i          in   synchronous active-high reset           |
// |              start_i        in   start level (sampled in IDLE/DONE)      |
// |              pattern_o      out  gate inputs A/B/C                       |
// |              drive_en_o     out  sequencer owns the gate inputs          |
// |              result_i       in   gate outputs [15:0]                     |
// |              busy_o         out  run in progress                         |
// |              done_o         out  run finished                            |
// |              pass_o         out  done with zero errors                   |
// |              fail_o         out  sticky mismatch flag                    |
// |              err_mask_o     out  sticky OR of mismatching bits           |
// |              err_cnt_o      out  saturating mismatch count               |
// |              fail_pattern_o out  pattern of first mismatch               |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module testboard_selftest_seq #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic [2:0]           pattern_o,
    output logic                 drive_en_o,
    input  logic [15:0]          result_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic [15:0]          err_mask_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [2:0]           fail_pattern_o
);

    import testboard_pkg::*;

    localparam int                c_SCNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_SCNT_W-1:0] c_SCNT_LAST = c_SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]        c_LAST_PAT  = 3'(NUM_PATTERNS - 1);

    state_e                  state_q, state_d;
    logic [c_SCNT_W-1:0]     settle_q, settle_d;
    logic [2:0]              pattern_q, pattern_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [NUM_RESULTS-1:0]  err_mask_q, err_mask_d;
    logic                    fail_q, fail_d;
    logic [2:0]              fail_pat_q, fail_pat_d;
    logic                    done_pulse_q, done_pulse_d;

    logic                    w_settle_done;
    logic                    w_last_pattern;
    logic [NUM_RESULTS-1:0]  w_diff;

    assign w_settle_done  = (settle_q == c_SCNT_LAST);
    assign w_last_pattern = (pattern_q == c_LAST_PAT);
    assign w_diff         = result_i ^ golden_result(pattern_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. start_i only matters in IDLE/DONE, so a run
    // can never be restarted part-way through.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) state_d = SETTLE;
            end
            SETTLE: begin
                if (w_settle_done) state_d = CHECK;
            end
            CHECK: begin
                if (w_last_pattern) begin
`ifdef SELFTEST_LOOP_EN
                    state_d = start_i ? SETTLE : DONE;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. done_pulse_q covers the loop case where the pass
    // ends but the sequencer goes straight back to SETTLE.
    // ------------------------------------------------------------------
    always_comb begin
        busy_o     = (state_q == SETTLE) || (state_q == CHECK);
        drive_en_o = busy_o;
        done_o     = (state_q == DONE) || done_pulse_q;
        pass_o     = done_o && (err_cnt_q == '0);
    end

    assign pattern_o      = pattern_q;
    assign fail_o         = fail_q;
    assign err_mask_o     = err_mask_q;
    assign err_cnt_o      = err_cnt_q;
    assign fail_pattern_o = fail_pat_q;

    // ------------------------------------------------------------------
    // Datapath: counters and error accumulators
    // ------------------------------------------------------------------
    always_comb begin
        settle_d     = settle_q;
        pattern_d    = pattern_q;
        err_cnt_d    = err_cnt_q;
        err_mask_d   = err_mask_q;
        fail_d       = fail_q;
        fail_pat_d   = fail_pat_q;
        done_pulse_d = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    settle_d   = '0;
                    pattern_d  = '0;
                    err_cnt_d  = '0;
                    err_mask_d = '0;
                    fail_d     = 1'b0;
                    fail_pat_d = '0;
                end
            end
            SETTLE: begin
                if (!w_settle_done) settle_d = settle_q + c_SCNT_W'(1);
            end
            CHECK: begin
                settle_d = '0;
                if (w_diff != '0) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    err_mask_d = err_mask_q | w_diff;
                    fail_d     = 1'b1;
                    if (!fail_q) fail_pat_d = pattern_q;
                end
                if (w_last_pattern) begin
                    done_pulse_d = 1'b1;
`ifdef SELFTEST_LOOP_EN
                    pattern_d = '0;
`endif
                end else begin
                    pattern_d = pattern_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            settle_q     <= '0;
            pattern_q    <= '0;
            err_cnt_q    <= '0;
            err_mask_q   <= '0;
            fail_q       <= 1'b0;
            fail_pat_q   <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            settle_q     <= settle_d;
            pattern_q    <= pattern_d;
            err_cnt_q    <= err_cnt_d;
            err_mask_q   <= err_mask_d;
            fail_q       <= fail_d;
            fail_pat_q   <= fail_pat_d;
            done_pulse_q <= done_pulse_d;
        end
    end

endmodule
`default_nettype wire
